axi_read_master: RTL and testbench

- AXI4 read-channel initiator (master side, AR + R only) that issues single INCR bursts on behalf of a simple core-side request port.
- It is the counterpart to the slave-side memory wrappers (ROM/SRAM). It sits between a CPU fetch/load unit and the AXI bridge master port.
- Returned beats pass through a small FIFO so that core back-pressure never stalls the R channel combinationally.

---
 rtl/axi_read_master.sv | 136 +++++++++++++
 tb/tb_axi_read_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master.sv
// AXI4 read-channel initiator: turns one core request into a single INCR burst
// and buffers returned beats in a small FIFO so core stalls never gate RREADY combinationally.
module axi_read_master #(
  parameter logic [3:0] ID_VAL     = 4'd0,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t         state;
  logic [4:0]     beat_cnt;

  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic           fifo_last [FIFO_DEPTH];
  logic           fifo_err  [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  logic fifo_empty, fifo_full;
  logic r_hs, in_range, beat_last, beat_err, push, pop;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign ARID_M    = ID_VAL;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  // Handshake outputs depend only on registered state, never on rsp_ready.
  assign req_ready = !ARESET && (state == IDLE) && fifo_empty;
  assign RREADY_M  = !ARESET && (state == DATA) && !fifo_full;
  assign rsp_valid = !ARESET && !fifo_empty;

  assign r_hs      = RVALID_M && RREADY_M;
  assign in_range  = (beat_cnt <= {1'b0, ARLEN_M});
  assign beat_last = (beat_cnt == {1'b0, ARLEN_M});
  assign beat_err  = (RRESP_M != 2'b00) || (RID_M != ID_VAL) || (RLAST_M != beat_last);
  assign push      = r_hs && in_range;
  assign pop       = rsp_valid && rsp_ready;

  assign rsp_data = fifo_data[rd_ptr];
  assign rsp_last = fifo_last[rd_ptr];
  assign rsp_err  = fifo_err[rd_ptr];

  // Control FSM: IDLE -> ADDR (AR issued) -> DATA (beats collected).
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      ARVALID_M <= 1'b0;
      ARADDR_M  <= '0;
      ARLEN_M   <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            ARADDR_M  <= {req_addr[31:2], 2'b00};
            ARLEN_M   <= req_len;
            beat_cnt  <= '0;
            ARVALID_M <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY_M) begin
            ARVALID_M <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            // Overrun beats past len are swallowed without advancing the counter.
            if (in_range) beat_cnt <= beat_cnt + 5'd1;
            if (RLAST_M)  state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // An early RLAST is forced to terminate the response stream for the core.
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= RDATA_M;
      fifo_last[wr_ptr] <= beat_last || RLAST_M;
      fifo_err[wr_ptr]  <= beat_err;
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master: bench-side AXI slave, scoreboarded core consumer.
module tb_axi_read_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;

  always #5 ACLK = ~ACLK;

  axi_read_master #(.ID_VAL(4'd0), .FIFO_DEPTH(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic l, input logic e);
    beat_t b;
    b.data = d; b.last = l; b.err = e;
    sb.push_back(b);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] len);
    int n;
    @(posedge ACLK); #1;
    req_valid = 1'b1; req_addr = addr; req_len = len;
    n = 0;
    forever begin
      @(negedge ACLK);
      if (req_ready) break;
      n++;
      if (n > 200) begin timeout("req_accept"); break; end
    end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
  endtask

  // Holds ARREADY low for 'delay' cycles of ARVALID, checking address stability.
  task automatic ar_accept(input int delay, input logic [31:0] ea, input logic [3:0] el);
    for (int d = 0; d < delay; d++) begin
      @(negedge ACLK);
      chk("arvalid_hold", ARVALID_M, 1'b1);
      chk("araddr_hold", ARADDR_M, ea);
      chk("arlen_hold", ARLEN_M, el);
      @(posedge ACLK); #1;
    end
    ARREADY_M = 1'b1;
    @(negedge ACLK);
    chk("arvalid", ARVALID_M, 1'b1);
    chk("araddr", ARADDR_M, ea);
    chk("arlen", ARLEN_M, el);
    @(posedge ACLK); #1;
    ARREADY_M = 1'b0;
    @(negedge ACLK);
    chk("arvalid_drop", ARVALID_M, 1'b0);
  endtask

  task automatic slave_burst(input int n, input int last_idx, input logic [3:0] rid,
                             input int err_idx, input logic [31:0] base);
    logic hs;
    int w;
    @(posedge ACLK); #1;
    for (int i = 0; i < n; i++) begin
      RVALID_M = 1'b1;
      RDATA_M  = base + 32'(i);
      RLAST_M  = (i == last_idx);
      RRESP_M  = (i == err_idx) ? 2'b10 : 2'b00;
      RID_M    = rid;
      w = 0;
      do begin
        @(negedge ACLK);
        hs = RREADY_M;
        @(posedge ACLK); #1;
        w++;
      end while (!hs && w < 200);
      if (!hs) begin timeout("r_beat"); break; end
    end
    RVALID_M = 1'b0;
    RLAST_M  = 1'b0;
    RRESP_M  = 2'b00;
    RID_M    = 4'd0;
  endtask

  task automatic consume(input int n, input int stall);
    int got, w;
    beat_t b;
    got = 0;
    w = 0;
    if (stall > 0) begin
      rsp_ready = 1'b0;
      do begin
        @(negedge ACLK);
        w++;
      end while (!rsp_valid && w < 200);
      if (!rsp_valid) timeout("bp_first_valid");
      for (int s = 0; s < stall; s++) begin
        @(posedge ACLK); #1;
      end
      @(negedge ACLK);
      chk("bp_rready_low", RREADY_M, 1'b0);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      @(posedge ACLK); #1;
    end
    rsp_ready = 1'b1;
    w = 0;
    while (got < n) begin
      @(negedge ACLK);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          timeout("sb_underflow");
        end else begin
          b = sb.pop_front();
          chk("rsp_data", rsp_data, b.data);
          chk("rsp_last", rsp_last, b.last);
          chk("rsp_err", rsp_err, b.err);
        end
        got++;
      end
      @(posedge ACLK); #1;
      w++;
      if (w > 400) begin timeout("rsp_beats"); break; end
    end
  endtask

  initial begin
    ARESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    ARREADY_M = 1'b0; RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 1'b0; RVALID_M = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arvalid", ARVALID_M, 1'b0);
    chk("rst_rready", RREADY_M, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_araddr", ARADDR_M, 32'h0);
    chk("rst_arlen", ARLEN_M, 4'h0);
    chk("const_arid", ARID_M, 4'h0);
    chk("const_arsize", ARSIZE_M, 3'b010);
    chk("const_arburst", ARBURST_M, 2'b01);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle_req_ready", req_ready, 1'b1);

    // Single beat, unaligned address.
    exp_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
    fork
      begin issue(32'h0000_1006, 4'd0); ar_accept(0, 32'h0000_1004, 4'd0);
            slave_burst(1, 0, 4'd0, -1, 32'hDEAD_BEEF); end
      consume(1, 0);
    join
    @(negedge ACLK);
    chk("single_req_ready", req_ready, 1'b1);
    chk("single_no_extra", rsp_valid, 1'b0);

    // 4-beat burst, ARREADY delayed 3 cycles.
    for (int i = 0; i < 4; i++) exp_beat(32'h1000 + 32'(i), i == 3, 1'b0);
    fork
      begin issue(32'h0000_2000, 4'd3); ar_accept(3, 32'h0000_2000, 4'd3);
            slave_burst(4, 3, 4'd0, -1, 32'h1000); end
      consume(4, 0);
    join

    // 8-beat burst with core back-pressure.
    for (int i = 0; i < 8; i++) exp_beat(32'h2000 + 32'(i), i == 7, 1'b0);
    fork
      begin issue(32'h0000_3000, 4'd7); ar_accept(0, 32'h0000_3000, 4'd7);
            slave_burst(8, 7, 4'd0, -1, 32'h2000); end
      consume(8, 5);
    join
    @(negedge ACLK);
    chk("bp_drained", rsp_valid, 1'b0);
    chk("bp_sb_empty", sb.size(), 0);

    // SLVERR on beat 2 of 3.
    for (int i = 0; i < 3; i++) exp_beat(32'h3000 + 32'(i), i == 2, i == 1);
    fork
      begin issue(32'h0000_4000, 4'd2); ar_accept(0, 32'h0000_4000, 4'd2);
            slave_burst(3, 2, 4'd0, 1, 32'h3000); end
      consume(3, 0);
    join

    // Wrong RID on every beat.
    for (int i = 0; i < 2; i++) exp_beat(32'h4000 + 32'(i), i == 1, 1'b1);
    fork
      begin issue(32'h0000_5000, 4'd1); ar_accept(0, 32'h0000_5000, 4'd1);
            slave_burst(2, 1, 4'h5, -1, 32'h4000); end
      consume(2, 0);
    join

    // Early RLAST on beat 2 of a 4-beat request.
    exp_beat(32'h5000, 1'b0, 1'b0);
    exp_beat(32'h5001, 1'b1, 1'b1);
    fork
      begin issue(32'h0000_6000, 4'd3); ar_accept(0, 32'h0000_6000, 4'd3);
            slave_burst(2, 1, 4'd0, -1, 32'h5000); end
      consume(2, 0);
    join
    @(negedge ACLK);
    chk("early_last_idle", req_ready, 1'b1);

    // Slave overrun: len=1 but 3 beats, third dropped.
    exp_beat(32'h6000, 1'b0, 1'b0);
    exp_beat(32'h6001, 1'b1, 1'b1);
    fork
      begin issue(32'h0000_7000, 4'd1); ar_accept(0, 32'h0000_7000, 4'd1);
            slave_burst(3, 2, 4'd0, -1, 32'h6000); end
      consume(2, 0);
    join
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("overrun_dropped", rsp_valid, 1'b0);
    chk("overrun_idle", req_ready, 1'b1);

    // Reset in the middle of the data phase.
    rsp_ready = 1'b0;
    issue(32'h0000_8000, 4'd3);
    ar_accept(0, 32'h0000_8000, 4'd3);
    slave_burst(1, -1, 4'd0, -1, 32'h7000);
    @(negedge ACLK);
    chk("mid_rst_buffered", rsp_valid, 1'b1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_arvalid", ARVALID_M, 1'b0);
    chk("mid_rst_rready", RREADY_M, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    chk("post_rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 2; i++) exp_beat(32'h8000 + 32'(i), i == 1, 1'b0);
    fork
      begin issue(32'h0000_9008, 4'd1); ar_accept(0, 32'h0000_9008, 4'd1);
            slave_burst(2, 1, 4'd0, -1, 32'h8000); end
      consume(2, 0);
    join
    @(negedge ACLK);
    chk("final_idle", req_ready, 1'b1);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
